// File: rtl/layer_ctrl_8_8.sv
// Sequencer for a fully connected layer at parallelism 1: loads an input vector,
// then walks the weight ROM one MAC per cycle and hands out one result per row.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOAD    | accept M input words into the input memory
// COMPUTE | issue M reads (input k, weight n*M+k), clear on the first
// DRAIN   | one extra cycle so the last product reaches the accumulator
// OUTPUT  | result valid, wait for downstream handshake
module layer_ctrl_8_8 #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(M)-1:0]     addr_x,
    output logic                     wr_en_x,
    output logic [$clog2(M*N)-1:0]   addr_w,
    output logic                     clear_acc,
    output logic                     en_acc
);

    localparam int XW = $clog2(M);
    localparam int WW = $clog2(M*N);
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(M-1);
    localparam logic [NW-1:0] N_LAST  = NW'(N-1);
    localparam logic [WW-1:0] WA_LAST = WW'(M*N-1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DRAIN   = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t          state;
    logic [XW-1:0]   ld;
    logic [XW-1:0]   k;
    logic [NW-1:0]   n;
    logic [WW-1:0]   wa;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_LOAD;
            ld     <= '0;
            k      <= '0;
            n      <= '0;
            wa     <= '0;
            en_acc <= 1'b0;
        end else begin
            // one-cycle delay lines accumulation up with the memory read latency
            en_acc <= (state == S_COMPUTE);
            case (state)
                S_LOAD: begin
                    if (s_valid) begin
                        if (ld == X_LAST) begin
                            ld    <= '0;
                            state <= S_COMPUTE;
                        end else begin
                            ld <= ld + XW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    wa <= (wa == WA_LAST) ? '0 : wa + WW'(1);
                    if (k == X_LAST) begin
                        k     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        k <= k + XW'(1);
                    end
                end
                S_DRAIN: begin
                    state <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (m_ready) begin
                        if (n == N_LAST) begin
                            n     <= '0;
                            wa    <= '0;
                            state <= S_LOAD;
                        end else begin
                            n     <= n + NW'(1);
                            state <= S_COMPUTE;
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    assign s_ready   = (state == S_LOAD);
    assign wr_en_x   = s_valid && s_ready;
    assign m_valid   = (state == S_OUTPUT);
    assign clear_acc = (state == S_COMPUTE) && (k == '0);
    assign addr_x    = (state == S_LOAD) ? ld : k;
    assign addr_w    = wa;

endmodule

// File: tb/tb_layer_ctrl_8_8.sv
// Randomized bench for layer_ctrl_8_8 against a schedule-level model: a vector
// is "loading" (count of words) or in output row n at offset j of its M+2 window.
module tb_layer_ctrl_8_8;
    localparam int M = 8;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic       s_ready;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] addr_x;
    logic       wr_en_x;
    logic [5:0] addr_w;
    logic       clear_acc;
    logic       en_acc;

    layer_ctrl_8_8 #(.M(M), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .addr_x    (addr_x),
        .wr_en_x   (wr_en_x),
        .addr_w    (addr_w),
        .clear_acc (clear_acc),
        .en_acc    (en_acc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        if (obs !== 32'(exp)) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model
    bit loading;
    int ld_cnt;
    int row;
    int j;

    // timing monitors
    int  cyc;
    int  last_wr_cyc;
    bit  lat_pending;
    int  last_rise;
    bit  full_rate;
    logic prev_s_ready, prev_m_valid;

    task automatic model_reset();
        loading     = 1'b1;
        ld_cnt      = 0;
        row         = 0;
        j           = 0;
        lat_pending = 1'b0;
        last_rise   = -1;
    endtask

    task automatic compare_outputs();
        int ex_ax, ex_aw;
        if (loading) begin
            ex_ax = ld_cnt;
            ex_aw = 0;
        end else if (j < M) begin
            ex_ax = j;
            ex_aw = row * M + j;
        end else begin
            ex_ax = 0;
            ex_aw = ((row + 1) * M) % (M * N);
        end
        check_val("s_ready",   32'(s_ready),   int'(loading));
        check_val("wr_en_x",   32'(wr_en_x),   int'(loading && s_valid));
        check_val("m_valid",   32'(m_valid),   int'(!loading && j >= M + 1));
        check_val("clear_acc", 32'(clear_acc), int'(!loading && j == 0));
        check_val("en_acc",    32'(en_acc),    int'(!loading && j >= 1 && j <= M));
        check_val("addr_x",    32'(addr_x),    ex_ax);
        check_val("addr_w",    32'(addr_w),    ex_aw);

        if (wr_en_x && addr_x == 3'(M - 1)) begin
            last_wr_cyc = cyc;
            lat_pending = 1'b1;
        end
        if (m_valid && !prev_m_valid && lat_pending) begin
            check_val("m_valid_latency", 32'(cyc - last_wr_cyc), M + 2);
            lat_pending = 1'b0;
        end
        if (s_ready && !prev_s_ready) begin
            if (full_rate && last_rise >= 0)
                check_val("vector_period", 32'(cyc - last_rise), M + N * (M + 2));
            last_rise = cyc;
        end
        prev_s_ready = s_ready;
        prev_m_valid = m_valid;
    endtask

    task automatic advance_model();
        if (loading) begin
            if (s_valid) begin
                ld_cnt++;
                if (ld_cnt == M) begin
                    loading = 1'b0;
                    ld_cnt  = 0;
                    row     = 0;
                    j       = 0;
                end
            end
        end else if (j <= M) begin
            j++;
        end else if (m_ready) begin
            if (row == N - 1) begin
                loading = 1'b1;
                row     = 0;
            end else begin
                row++;
            end
            j = 0;
        end
    endtask

    task automatic drive(input int pv, input int pr);
        @(negedge clk);
        s_valid = ($urandom_range(99) < pv);
        m_ready = ($urandom_range(99) < pr);
        #1;
        cyc++;
        compare_outputs();
    endtask

    task automatic run_cycles(input int cnt, input int pv, input int pr);
        full_rate = (pv == 100 && pr == 100);
        last_rise = -1;
        for (int i = 0; i < cnt; i++) begin
            drive(pv, pr);
            advance_model();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_s_ready"},   32'(s_ready),   1);
        check_val({tag, "_m_valid"},   32'(m_valid),   0);
        check_val({tag, "_addr_w"},    32'(addr_w),    0);
        check_val({tag, "_addr_x"},    32'(addr_x),    0);
        check_val({tag, "_en_acc"},    32'(en_acc),    0);
        check_val({tag, "_clear_acc"}, 32'(clear_acc), 0);
    endtask

    initial begin
        bit hit;
        cyc          = 0;
        prev_s_ready = 1'b0;
        prev_m_valid = 1'b0;
        full_rate    = 1'b0;
        reset        = 1'b1;
        s_valid      = 1'b1;
        m_ready      = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("rst");
        check_val("rst_wr_en_x", 32'(wr_en_x), 1);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        reset   = 1'b0;

        run_cycles(400, 100, 100);
        run_cycles(2500, 50, 50);
        run_cycles(600, 30, 80);

        // async reset in the middle of row 3, k = 4
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            drive(100, 100);
            if (!loading && row == 3 && j == 4) hit = 1'b1;
            else advance_model();
        end
        check_val("midrst_reached", 32'(hit), 1);
        check_val("midrst_pre_en_acc", 32'(en_acc), 1);
        reset   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        prev_s_ready = 1'b1;
        prev_m_valid = 1'b0;

        run_cycles(300, 100, 100);
        run_cycles(800, 70, 40);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
